mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, address width.
REQ-002 The block SHALL have parameter DW, default 32, data width.
REQ-003 The block SHALL have parameter WAIT, default 1, memory wait cycles, legal 0..7.
REQ-004 The block SHALL have parameter MAX_STARVE, default 3, maximum consecutive LS grants while IF is pending, legal 1..7.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset, with ports as follows:
- CLK  in  1  clock, rising edge.
- RST_F  in  1  asynchronous active-low reset.
- IF_REQ  in  1  instruction-fetch read request.
- IF_ADDR  in  AW  fetch address.
- IF_GNT  out  1  fetch grant pulse.
- IF_RDATA  out  DW  fetch read data.
- IF_VALID  out  1  fetch data-valid pulse.
- LS_REQ  in  1  load/store request.
- LS_WE  in  1  1 = store, 0 = load.
- LS_ADDR  in  AW  load/store address.
- LS_WDATA  in  DW  store data.
- LS_GNT  out  1  load/store grant pulse.
- LS_RDATA  out  DW  load data.
- LS_VALID  out  1  load/store completion pulse.
- MEM_EN  out  1  memory access strobe.
- MEM_WE  out  1  memory write strobe.
- MEM_ADDR  out  AW  memory address.
- MEM_WDATA  out  DW  memory write data.
- MEM_RDATA  in  DW  memory read data.
- BUSY  out  1  high in every state except IDLE.

Function
REQ-006 The block SHALL implement the states IDLE, ACCESS, WAITST and DONE.
REQ-007 IDLE SHALL go to ACCESS when IF_REQ or LS_REQ is high at the clock edge; otherwise it SHALL stay in IDLE.
REQ-008 When both requests are high, LS SHALL win, unless starve_cnt equals MAX_STARVE, in which case IF SHALL win.
REQ-009 starve_cnt SHALL increment, saturating at MAX_STARVE, on each LS grant while IF_REQ is high.
REQ-010 starve_cnt SHALL clear on any IF grant, and on any edge where IF_REQ is low.
REQ-011 On entry to ACCESS, the block SHALL latch the winner ID, address, LS_WE and LS_WDATA.
REQ-012 The winner's GNT SHALL be high for exactly the single ACCESS cycle.
REQ-013 In ACCESS, MEM_EN SHALL be 1, and MEM_WE SHALL equal the latched write flag (IF is always a read).
REQ-014 MEM_EN and MEM_WE SHALL be 0 in every state other than ACCESS.
REQ-015 MEM_ADDR and MEM_WDATA SHALL hold the latched values from ACCESS through DONE.
REQ-016 After ACCESS, the block SHALL go to WAITST when WAIT > 0, otherwise directly to DONE.
REQ-017 WAITST SHALL count WAIT cycles with a 3-bit down-counter, then go to DONE.
REQ-018 On the edge entering DONE, a read SHALL capture MEM_RDATA into the winner's RDATA register.
REQ-019 In DONE, the winner's VALID SHALL be high for exactly one cycle, for reads and for writes; DONE SHALL then go to IDLE.
REQ-020 Latency SHALL be: request sampled at edge N, then GNT in cycle N+1, then VALID in cycle N+2+WAIT.
REQ-021 IF_RDATA and LS_RDATA SHALL hold their values until the next read completion to the same requester.
REQ-022 A store SHALL never update LS_RDATA.
REQ-023 A requester SHALL hold REQ and its operands until it sees GNT.
REQ-024 A REQ withdrawn before grant SHALL cause no memory access.
REQ-025 A REQ still high in the DONE cycle SHALL be treated as a new request in the following IDLE cycle, with no bubble beyond IDLE.
REQ-026 New requests arriving during ACCESS, WAITST or DONE SHALL be ignored until IDLE.
REQ-027 At most one GNT and at most one VALID SHALL be high in any cycle.

Reset
REQ-028 RST_F low SHALL immediately force:
- state to IDLE;
- starve_cnt and the wait counter to 0;
- all GNT, VALID, MEM_EN, MEM_WE and BUSY outputs to 0;
- MEM_ADDR, MEM_WDATA, IF_RDATA and LS_RDATA to 0.
REQ-029 A reset during ACCESS, WAITST or DONE SHALL abandon the access with no VALID ever issued for it.
REQ-030 After RST_F deasserts, the first request SHALL be arbitrated normally.

Verification
REQ-031 With WAIT=1, IF_REQ=1, IF_ADDR=0x10 and mem[0x10]=0xDEADBEEF, the bench SHALL see IF_GNT one cycle later, then IF_VALID two cycles after that with IF_RDATA=0xDEADBEEF, and MEM_WE=0 throughout.
REQ-032 With LS_REQ=1, LS_WE=1, LS_ADDR=0x20 and LS_WDATA=0x12345678, the bench SHALL see MEM_WE=1 for exactly one cycle and LS_VALID=1 once; a following load from 0x20 SHALL return 0x12345678.
REQ-033 With IF_REQ and LS_REQ both held high continuously and MAX_STARVE=3, the grant order SHALL be LS, LS, LS, IF, then repeat.
REQ-034 With WAIT=0, back-to-back LS loads SHALL produce a VALID every 3 cycles, each carrying the correct data.
REQ-035 With RST_F pulsed low during WAITST of an IF read, the bench SHALL see no IF_VALID, all outputs 0 and BUSY=0; a new request after reset SHALL complete normally.
REQ-036 With IF_REQ raised and then dropped before grant while LS is in WAITST, MEM_EN SHALL never assert for IF_ADDR and IF_GNT SHALL stay 0.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// Two-requester memory arbiter: instruction fetch (IF) and load/store (LS) share one
// single-port memory with fixed wait states; LS has priority, bounded by a starvation limit.
module mem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int WAIT       = 1,
    parameter int MAX_STARVE = 3
) (
    input  logic          CLK,
    input  logic          RST_F,
    input  logic          IF_REQ,
    input  logic [AW-1:0] IF_ADDR,
    output logic          IF_GNT,
    output logic [DW-1:0] IF_RDATA,
    output logic          IF_VALID,
    input  logic          LS_REQ,
    input  logic          LS_WE,
    input  logic [AW-1:0] LS_ADDR,
    input  logic [DW-1:0] LS_WDATA,
    output logic          LS_GNT,
    output logic [DW-1:0] LS_RDATA,
    output logic          LS_VALID,
    output logic          MEM_EN,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_WDATA,
    input  logic [DW-1:0] MEM_RDATA,
    output logic          BUSY
);

    // Handshake: a requester raises REQ with stable operands and holds both until its
    // one-cycle GNT; completion is a one-cycle VALID. REQ is only sampled while IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAITST = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_LOAD  = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;
    localparam logic [2:0] STARVE_TOP = 3'(MAX_STARVE);

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    wait_cnt;
    logic [2:0]    starve_cnt;
    logic          sel_ls;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] ls_rdata_q;
    logic          pick_ls;
    logic          arb_fire;
    logic          enter_done;

    // LS wins ties unless fetch has already been passed over MAX_STARVE times in a row.
    assign pick_ls  = LS_REQ && !(IF_REQ && (starve_cnt == STARVE_TOP));
    assign arb_fire = (state == IDLE) && (IF_REQ || LS_REQ);

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        enter_done = 1'b0;
        IF_GNT     = 1'b0;
        LS_GNT     = 1'b0;
        IF_VALID   = 1'b0;
        LS_VALID   = 1'b0;
        MEM_EN     = 1'b0;
        MEM_WE     = 1'b0;
        BUSY       = 1'b0;
        case (state)
            IDLE: begin
                if (IF_REQ || LS_REQ) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                BUSY   = 1'b1;
                MEM_EN = 1'b1;
                MEM_WE = we_q;
                IF_GNT = !sel_ls;
                LS_GNT = sel_ls;
                if (WAIT > 0) begin
                    state_nxt = WAITST;
                end else begin
                    state_nxt  = DONE;
                    enter_done = 1'b1;
                end
            end
            WAITST: begin
                BUSY = 1'b1;
                if (wait_cnt == 3'd0) begin
                    state_nxt  = DONE;
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                BUSY      = 1'b1;
                IF_VALID  = !sel_ls;
                LS_VALID  = sel_ls;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Winner and operands are captured once, at the arbitration edge, and held to DONE.
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            sel_ls  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (arb_fire) begin
            sel_ls  <= pick_ls;
            we_q    <= pick_ls && LS_WE;
            addr_q  <= pick_ls ? LS_ADDR : IF_ADDR;
            wdata_q <= LS_WDATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            wait_cnt <= 3'd0;
        end else if (state == ACCESS) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == WAITST) && (wait_cnt != 3'd0)) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            starve_cnt <= 3'd0;
        end else if (!IF_REQ) begin
            starve_cnt <= 3'd0;
        end else if (arb_fire && !pick_ls) begin
            starve_cnt <= 3'd0;
        end else if (arb_fire && pick_ls && (starve_cnt != STARVE_TOP)) begin
            starve_cnt <= starve_cnt + 3'd1;
        end
    end

    // Read data lands in the winner's register on the edge that enters DONE; stores never touch it.
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else if (enter_done && !we_q) begin
            if (sel_ls) begin
                ls_rdata_q <= MEM_RDATA;
            end else begin
                if_rdata_q <= MEM_RDATA;
            end
        end
    end

    assign IF_RDATA  = if_rdata_q;
    assign LS_RDATA  = ls_rdata_q;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;

endmodule
